// File: rtl/frontend_cmd_definition_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : frontend_cmd_definition_pkg
//  Description : Shared command definitions between the Global_Controller
//                frontend and the per-channel backend controllers.
//                Provides backend_command_t and the default queue depths
//                used by backend_frontend_if.
//                Also supplies a fallback for `GLOBAL_CONTROLLER_WORD_SIZE
//                when the system build does not define it.
//  Revision    : 1.1 - added BC_CMD_DEPTH_DEFAULT / BC_RDQ_DEPTH_DEFAULT
// ============================================================================

`ifndef GLOBAL_CONTROLLER_WORD_SIZE
`define GLOBAL_CONTROLLER_WORD_SIZE 32
`endif

package frontend_cmd_definition_pkg;

    typedef enum logic [1:0] {
        BC_OP_NOP     = 2'd0,
        BC_OP_READ    = 2'd1,
        BC_OP_WRITE   = 2'd2,
        BC_OP_REFRESH = 2'd3
    } backend_op_t;

    typedef struct packed {
        backend_op_t op;
        logic [3:0]  bank;
        logic [15:0] row;
        logic [9:0]  col;
    } backend_command_t;

    // Default queue depths for one backend channel (powers of two).
    localparam int BC_CMD_DEPTH_DEFAULT = 8;
    localparam int BC_RDQ_DEPTH_DEFAULT = 8;

endpackage : frontend_cmd_definition_pkg

`default_nettype wire

// File: rtl/backend_frontend_if_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : bc_sync_fifo
//  Description : Generic single-clock show-ahead FIFO. The head entry is
//                always visible on o_pop_data while o_empty is low.
//                A push at full is accepted only when a pop happens in the
//                same cycle; a pop at empty is ignored.
//  Ports       : i_clk, i_rst (sync, active high)
//                i_push / i_push_data   - write side
//                i_pop  / o_pop_data    - read side (show-ahead)
//                o_full, o_empty, o_count (width clog2(DEPTH)+1)
//  Revision    : 1.0 - initial release
// ============================================================================
module bc_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_pop_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = $clog2(DEPTH) + 1;

    localparam logic [c_ptr_w-1:0] c_ptr_one  = {{(c_ptr_w-1){1'b0}}, 1'b1};
    localparam logic [c_cnt_w-1:0] c_cnt_one  = {{(c_cnt_w-1){1'b0}}, 1'b1};
    localparam logic [c_cnt_w-1:0] c_cnt_full = c_cnt_w'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_full     = (r_count == c_cnt_full);
    assign o_empty    = (r_count == '0);
    assign o_count    = r_count;
    assign o_pop_data = r_mem[r_rd_ptr];

    // A pop frees the slot the simultaneous push lands in, so full+pop+push
    // is legal.
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + c_cnt_one;
            end else if (!w_do_push && w_do_pop) begin
                r_count <= r_count - c_cnt_one;
            end
        end
    end

    // Storage carries no reset; validity is tracked by r_count alone.
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

endmodule : bc_sync_fifo

`default_nettype wire

// File: rtl/backend_frontend_if.sv
`default_nettype none
// ============================================================================
//  Module      : backend_frontend_if
//  Description : Per-channel ingress/egress buffer on the backend side of a
//                Global_Controller channel.
//                - Command path: frontend command + write data are queued
//                  together and presented show-ahead to the scheduler.
//                - Return path: DRAM read data is queued and handed back on
//                  the Global_Controller read-enable pull (1-cycle latency).
//                - Generates the registered backend-controller-ready.
//  Ports       : i_clk, i_rst (sync, active high)
//                i_frontend_command_valid / i_frontend_command /
//                i_frontend_write_data / o_backend_controller_ready
//                o_cmd_valid / o_cmd / o_cmd_wdata / i_cmd_pop
//                i_rd_data_valid / i_rd_data / o_rdq_full
//                i_backend_controller_ren / o_returned_data_valid /
//                o_returned_data
//                o_overflow, o_underflow (sticky until reset)
//  Build macro : BACKEND_FRONTEND_IF_BYPASS_EN - when defined, a command
//                accepted into an empty queue while the scheduler pops is
//                passed straight through combinationally.
//  Revision    : 1.0 - initial release
// ============================================================================

`ifndef GLOBAL_CONTROLLER_WORD_SIZE
`define GLOBAL_CONTROLLER_WORD_SIZE 32
`endif

module backend_frontend_if
    import frontend_cmd_definition_pkg::*;
#(
    parameter int CMD_DEPTH = BC_CMD_DEPTH_DEFAULT,
    parameter int RDQ_DEPTH = BC_RDQ_DEPTH_DEFAULT,
    parameter int WORD_W    = `GLOBAL_CONTROLLER_WORD_SIZE
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_frontend_command_valid,
    input  backend_command_t      i_frontend_command,
    input  logic [WORD_W-1:0]     i_frontend_write_data,
    output logic                  o_backend_controller_ready,
    output logic                  o_cmd_valid,
    output backend_command_t      o_cmd,
    output logic [WORD_W-1:0]     o_cmd_wdata,
    input  logic                  i_cmd_pop,
    input  logic                  i_rd_data_valid,
    input  logic [WORD_W-1:0]     i_rd_data,
    output logic                  o_rdq_full,
    input  logic                  i_backend_controller_ren,
    output logic                  o_returned_data_valid,
    output logic [WORD_W-1:0]     o_returned_data,
    output logic                  o_overflow,
    output logic                  o_underflow
);

    localparam int c_cmd_w       = $bits(backend_command_t);
    localparam int c_cmd_entry_w = c_cmd_w + WORD_W;
    localparam int c_cmd_cnt_w   = $clog2(CMD_DEPTH) + 1;
    localparam int c_rdq_cnt_w   = $clog2(RDQ_DEPTH) + 1;

    localparam logic [c_cmd_cnt_w-1:0] c_cmd_cnt_one  = {{(c_cmd_cnt_w-1){1'b0}}, 1'b1};
    localparam logic [c_cmd_cnt_w-1:0] c_cmd_cnt_full = c_cmd_cnt_w'(CMD_DEPTH);

    // ------------------------------------------------------------------
    // Command path
    // ------------------------------------------------------------------
    logic                     r_ready;
    logic                     w_accept;
    logic                     w_bypass;
    logic                     w_cmd_push;
    logic                     w_cmd_pop;
    logic                     w_cmd_full;
    logic                     w_cmd_empty;
    logic [c_cmd_cnt_w-1:0]   w_cmd_count;
    logic [c_cmd_cnt_w-1:0]   w_cmd_count_next;
    logic [c_cmd_entry_w-1:0] w_cmd_head;
    backend_command_t         w_head_cmd;
    logic [WORD_W-1:0]        w_head_wdata;

    assign w_accept     = i_frontend_command_valid && r_ready;
    assign w_head_cmd   = w_cmd_head[c_cmd_entry_w-1 -: c_cmd_w];
    assign w_head_wdata = w_cmd_head[WORD_W-1:0];

`ifdef BACKEND_FRONTEND_IF_BYPASS_EN
    // Empty queue: the incoming command is the logical head. If the
    // scheduler pops it in the same cycle it never touches storage.
    assign w_bypass    = w_cmd_empty && w_accept && i_cmd_pop;
    assign o_cmd_valid = !w_cmd_empty || w_accept;
    assign o_cmd       = w_cmd_empty ? i_frontend_command    : w_head_cmd;
    assign o_cmd_wdata = w_cmd_empty ? i_frontend_write_data : w_head_wdata;
`else
    assign w_bypass    = 1'b0;
    assign o_cmd_valid = !w_cmd_empty;
    assign o_cmd       = w_head_cmd;
    assign o_cmd_wdata = w_head_wdata;
`endif

    // r_ready already guarantees a free slot; w_cmd_full is a backstop.
    assign w_cmd_push = w_accept && !w_bypass && !w_cmd_full;
    assign w_cmd_pop  = i_cmd_pop && !w_cmd_empty;

    always_comb begin
        w_cmd_count_next = w_cmd_count;
        if (w_cmd_push && !w_cmd_pop) begin
            w_cmd_count_next = w_cmd_count + c_cmd_cnt_one;
        end else if (!w_cmd_push && w_cmd_pop) begin
            w_cmd_count_next = w_cmd_count - c_cmd_cnt_one;
        end
    end

    bc_sync_fifo #(
        .WIDTH (c_cmd_entry_w),
        .DEPTH (CMD_DEPTH)
    ) u_cmd_fifo (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_push      (w_cmd_push),
        .i_push_data ({i_frontend_command, i_frontend_write_data}),
        .i_pop       (w_cmd_pop),
        .o_pop_data  (w_cmd_head),
        .o_full      (w_cmd_full),
        .o_empty     (w_cmd_empty),
        .o_count     (w_cmd_count)
    );

    // ------------------------------------------------------------------
    // Read-return path
    // ------------------------------------------------------------------
    logic                   w_rdq_push;
    logic                   w_rdq_pop;
    logic                   w_rdq_full;
    logic                   w_rdq_empty;
    logic [c_rdq_cnt_w-1:0] w_rdq_count;
    logic [WORD_W-1:0]      w_rdq_head;
    logic                   r_ret_valid;
    logic [WORD_W-1:0]      r_ret_data;
    logic                   r_overflow;
    logic                   r_underflow;

    assign w_rdq_pop  = i_backend_controller_ren && !w_rdq_empty;
    // Full with a concurrent pop still has room for the incoming word.
    assign w_rdq_push = i_rd_data_valid && (!w_rdq_full || w_rdq_pop);

    bc_sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (RDQ_DEPTH)
    ) u_rdq_fifo (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_push      (w_rdq_push),
        .i_push_data (i_rd_data),
        .i_pop       (w_rdq_pop),
        .o_pop_data  (w_rdq_head),
        .o_full      (w_rdq_full),
        .o_empty     (w_rdq_empty),
        .o_count     (w_rdq_count)
    );

    // Occupancy is reported through the full/empty flags only.
    logic w_unused;
    assign w_unused = ^w_rdq_count;

    // ------------------------------------------------------------------
    // Registered outputs: ready, returned data, sticky error flags
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ready     <= 1'b0;
            r_ret_valid <= 1'b0;
            r_ret_data  <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            // Looking at next-cycle occupancy keeps ready from ever
            // admitting a push into a full queue.
            r_ready     <= (w_cmd_count_next != c_cmd_cnt_full);
            r_ret_valid <= w_rdq_pop;
            if (w_rdq_pop) begin
                r_ret_data <= w_rdq_head;
            end
            if (i_rd_data_valid && !w_rdq_push) begin
                r_overflow <= 1'b1;
            end
            if (i_backend_controller_ren && w_rdq_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign o_backend_controller_ready = r_ready;
    assign o_rdq_full                 = w_rdq_full;
    assign o_returned_data_valid      = r_ret_valid;
    assign o_returned_data            = r_ret_data;
    assign o_overflow                 = r_overflow;
    assign o_underflow                = r_underflow;

endmodule : backend_frontend_if

`default_nettype wire
